// File: rtl/elm_pkg.sv
// Shared definitions for the ELM pixel streamer.
//  - elm_state_e : image-level FSM encoding (IDLE, FETCH, DRAIN, DONE)
//  - SKID_DEPTH  : number of output buffer entries; this also bounds the read credit
//  - credit_ok() : decides whether one more memory read may be issued this cycle
package elm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } elm_state_e;

  localparam int SKID_DEPTH = 2;

  // occupancy counts buffered entries plus the read in flight. A pop in the same
  // cycle frees a slot before the new read data can land, so it is subtracted.
  function automatic logic credit_ok(input logic [2:0] occupancy, input logic pop);
    return (occupancy - {2'b00, pop}) < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/elm_skid_buf.sv
// Two-entry FIFO that holds {last, data} between the memory read port and the
// stream output. The head entry drives the outputs directly from registers.
// Ports:
//  clk, rst         clock, asynchronous active-high reset
//  push_i, din_i    write one entry
//  pop_i            remove the head entry (caller only pops when not empty)
//  dout_o, valid_o  head entry and its valid flag (both registered)
//  full_o, empty_o  occupancy flags
// A simultaneous push and pop are legal in every state, including when full.
module elm_skid_buf #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         valid_q;
  logic         full_q;

  // Entry storage and occupancy; the tail entry is only meaningful while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (!valid_q) begin
            head_q  <= din_i;
            valid_q <= 1'b1;
          end else if (!full_q) begin
            tail_q <= din_i;
            full_q <= 1'b1;
          end
        end
        2'b01: begin
          if (full_q) begin
            head_q <= tail_q;
            full_q <= 1'b0;
          end else begin
            valid_q <= 1'b0;
          end
        end
        2'b11: begin
          // Full: tail moves up and the new entry takes its place.
          if (full_q) begin
            head_q <= tail_q;
            tail_q <= din_i;
          end else begin
            head_q <= din_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dout_o  = head_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign empty_o = ~valid_q;

endmodule

// File: rtl/elm_pixel_streamer.sv
// Fetches one image of NUM_PIX pixels from a synchronous memory (1-cycle read
// latency, same clock) and streams them in address order over valid/ready.
// Ports:
//  clk, rst            clock, asynchronous active-high reset
//  start               begin one image (only looked at in IDLE)
//  mem_addr, mem_data  memory read address / data returned one cycle later
//  m_valid, m_ready    output handshake; m_data is the pixel, m_last marks the final one
//  busy, done          busy while fetching/draining; done pulses once per image
//  checksum            (only with ELM_STREAM_CHECKSUM_EN defined) sum of the pixels
//                      transferred in the current image
// Configuration macro: ELM_STREAM_CHECKSUM_EN adds the checksum port and accumulator.
module elm_pixel_streamer
  import elm_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int ADDR_W    = 8,
  parameter int NUM_PIX   = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
`ifdef ELM_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W+ADDR_W:0] checksum
`endif
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + NUM_PIX - 1);

  elm_state_e        state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              busy_q;
  logic              done_q;

  logic              pop;
  logic              issue;
  logic              issue_last;
  logic [2:0]        occupancy;
  logic              skid_valid;
  logic              skid_full;
  logic              skid_empty;
  logic [DATA_W:0]   skid_head;

  assign pop        = ~skid_empty & m_ready;
  assign occupancy  = {2'b00, skid_valid} + {2'b00, skid_full} + {2'b00, inflight_q};
  assign issue_last = issue & (mem_addr_q == LAST_ADDR);

  // Read issue. The first read goes out in the same cycle start is accepted,
  // because mem_addr already rests on the first pixel address in IDLE.
  always_comb begin
    issue = 1'b0;
    case (state_q)
      ST_IDLE:  issue = start;
      ST_FETCH: issue = credit_ok(occupancy, pop);
      default:  issue = 1'b0;
    endcase
  end

  // Next read address; it returns to the first pixel once the last read is out
  // so IDLE is always ready for the next image.
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (issue_last) begin
      mem_addr_d = FIRST_ADDR;
    end else if (issue) begin
      mem_addr_d = mem_addr_q + ADDR_W'(1);
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  // Image FSM with its registered status outputs, address counter and in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mem_addr_q      <= FIRST_ADDR;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      mem_addr_q      <= mem_addr_d;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          done_q <= 1'b0;
          if (issue_last) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The tagged last pixel leaving the buffer ends the image.
          if (pop && skid_head[DATA_W]) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            done_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  elm_skid_buf #(
    .W(DATA_W + 1)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .pop_i  (pop),
    .din_i  ({inflight_last_q, mem_data}),
    .dout_o (skid_head),
    .valid_o(skid_valid),
    .full_o (skid_full),
    .empty_o(skid_empty)
  );

`ifdef ELM_STREAM_CHECKSUM_EN
  localparam int CS_W = DATA_W + ADDR_W + 1;
  logic [CS_W-1:0] checksum_q;

  // Per-image pixel sum: cleared on an accepted start, held after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + CS_W'(skid_head[DATA_W-1:0]);
    end else begin
      checksum_q <= checksum_q;
    end
  end

  assign checksum = checksum_q;
`endif

  assign mem_addr = mem_addr_q;
  assign m_valid  = skid_valid;
  assign m_data   = skid_head[DATA_W-1:0];
  assign m_last   = skid_head[DATA_W];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_elm_pixel_streamer.sv
// Self-checking bench for elm_pixel_streamer: a reference model (memory image
// plus expected pixel queue) feeds a scoreboard that a monitor drains whenever
// a transfer happens. Covers latency, random/toggling back-pressure, long
// stall, reset mid-image and start held high.
module tb_elm_pixel_streamer;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NP = 20;
  localparam int BA = 40;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
`ifdef ELM_STREAM_CHECKSUM_EN
  logic [DW+AW:0] checksum;
`endif

  elm_pixel_streamer #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_PIX(NP), .BASE_ADDR(BA)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy),
    .done    (done)
`ifdef ELM_STREAM_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  // Reference state
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW:0]   exp_q[$];
  int            sum_q[$];
  int            last_sum;
  int            checks;
  int            errors;
  int            xfer_cnt;
  int            ready_mode;  // 0 always ready, 1 random, 2 toggle, 3 never

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered 1-cycle read memory
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Load memory (pattern 0: pixel i = i, 1: random, 2: keep) and queue the expected image.
  task automatic load_image(input int pattern, input int copies);
    int s;
    s = 0;
    for (int i = 0; i < NP; i++) begin
      if (pattern == 0) mem[BA+i] = DW'(i);
      else if (pattern == 1) mem[BA+i] = DW'($urandom);
      s += int'(mem[BA+i]);
    end
    for (int c = 0; c < copies; c++) begin
      for (int i = 0; i < NP; i++) exp_q.push_back({(i == NP-1) ? 1'b1 : 1'b0, mem[BA+i]});
      sum_q.push_back(s);
    end
    last_sum = s;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: done not seen within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_image(input int mode, input int pattern);
    int prev_sum;
    prev_sum = last_sum;
    ready_mode = mode;
`ifdef ELM_STREAM_CHECKSUM_EN
    chk("cs_held", 32'(checksum), 32'(prev_sum));
`endif
    load_image(pattern, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("run_busy", 32'(busy), 32'd1);
`ifdef ELM_STREAM_CHECKSUM_EN
    chk("cs_clear", 32'(checksum), 32'd0);
`endif
    wait_done(20 * NP);
  endtask

  // Back-pressure driver
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = ~m_ready;
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        prev_stall;
    logic        exp_done;
    logic        nxt_done;
    logic [DW:0] prev_word;
    logic [DW:0] w;
    prev_stall = 1'b0;
    exp_done   = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        exp_done   = 1'b0;
      end else begin
        chk("done_pulse", 32'(done), 32'(exp_done));
        if (exp_done) chk("busy_at_done", 32'(busy), 32'd0);
`ifdef ELM_STREAM_CHECKSUM_EN
        if (done) begin
          if (sum_q.size() > 0) chk("checksum", 32'(checksum), 32'(sum_q.pop_front()));
          else begin checks++; errors++; $display("FAIL checksum: no expected sum"); end
        end
`endif
        if (prev_stall) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'({m_last, m_data}), 32'(prev_word));
        end
        nxt_done = 1'b0;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pixel: unexpected transfer got %0d", {m_last, m_data});
          end else begin
            w = exp_q.pop_front();
            chk("pixel", 32'({m_last, m_data}), 32'(w));
            nxt_done = w[DW];
          end
          xfer_cnt++;
        end
        prev_stall = m_valid && !m_ready;
        prev_word  = {m_last, m_data};
        exp_done   = nxt_done;
      end
    end
  end

  initial begin
    int k;
    int x0;
    int n;
    checks = 0; errors = 0; xfer_cnt = 0; last_sum = 0;
    ready_mode = 3;
    rst = 1'b1; start = 1'b0; mem_data = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'(BA));
    chk("rst_data", 32'({m_last, m_data}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency with m_ready=1
    ready_mode = 0;
    @(posedge clk); #1;
    load_image(0, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("lat_busy_t1", 32'(busy), 32'd1);
    chk("lat_valid_t1", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid_t2", 32'(m_valid), 32'd1);
    k = 2;
    while (!done && k < NP + 40) begin
      @(negedge clk);
      k++;
    end
    chk("lat_done_cycle", 32'(k), 32'(NP + 2));
    chk("lat_busy_done", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Random and toggling back-pressure
    run_image(1, 1);
    run_image(2, 1);
    run_image(1, 1);
    run_image(0, 1);

    // Long stall: only two reads may be outstanding
    ready_mode = 3;
    @(posedge clk); #1;
    load_image(1, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("stall_addr", 32'(mem_addr), 32'(BA + 2));
    chk("stall_valid", 32'(m_valid), 32'd1);
    ready_mode = 0;
    wait_done(20 * NP);

    // Reset after 7 transfers
    ready_mode = 0;
    @(posedge clk); #1;
    load_image(1, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x0 = xfer_cnt;
    n = 0;
    while ((xfer_cnt - x0) < 7 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst_xfers", 32'(xfer_cnt - x0), 32'd7);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_last", 32'(m_last), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'(BA));
`ifdef ELM_STREAM_CHECKSUM_EN
    chk("mid_rst_cs", 32'(checksum), 32'd0);
`endif
    exp_q.delete();
    sum_q.delete();
    last_sum = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    run_image(1, 2);

    // start held high: one image, one done, restart one cycle after done
    ready_mode = 1;
    load_image(1, 2);
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20 * NP);
    chk("held_done_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("held_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("held_restart_busy", 32'(busy), 32'd1);
    wait_done(20 * NP);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
